// File: rtl/circular_delay_mc.sv
// circular_delay_mc: NCH-channel run-time-programmable delay line (ports: clk, rst async, ce, din, delay, delay_load -> dout, dout_valid, cur_delay)
module circular_delay_mc #(
  parameter int NCH = 4,
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int DEFAULT_DELAY = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic [NCH*DW-1:0]   din,
  input  logic [AW-1:0]       delay,
  input  logic                delay_load,
  output logic [NCH*DW-1:0]   dout,
  output logic                dout_valid,
  output logic [AW-1:0]       cur_delay
);
  logic [NCH*DW-1:0] mem [2**AW];
  logic [AW-1:0] wp, fill, delay_r, ra;
  logic [NCH*DW-1:0] rd;
  assign ra = wp - delay_r;
  assign rd = delay_r == '0 ? din : mem[ra];
  assign cur_delay = delay_r;
  always_ff @(posedge clk)
    if (ce) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      fill <= '0;
      delay_r <= AW'(DEFAULT_DELAY);
      dout <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (ce) wp <= wp + 1'b1;
      if (delay_load) begin
        delay_r <= delay;
        dout_valid <= 1'b0;
        fill <= AW'(ce);
      end else if (ce) begin
        dout <= rd;
        dout_valid <= fill >= delay_r;
        fill <= fill >= delay_r ? delay_r : fill + 1'b1;
      end
    end
endmodule

// File: tb/tb_circular_delay_mc.sv
// tb_circular_delay_mc: directed self-checking bench for circular_delay_mc
module tb_circular_delay_mc;
  logic clk = 0, rst = 1, ce = 0, delay_load = 0;
  logic [31:0] din = 0, dout;
  logic [3:0] delay = 0, cur_delay;
  logic dout_valid;
  int checks = 0, errors = 0;
  circular_delay_mc dut (
    .clk(clk), .rst(rst), .ce(ce), .din(din), .delay(delay), .delay_load(delay_load),
    .dout(dout), .dout_valid(dout_valid), .cur_delay(cur_delay)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] pk(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic c, input logic [31:0] d, input logic ld, input logic [3:0] dl);
    ce = c;
    din = d;
    delay_load = ld;
    delay = dl;
    @(posedge clk);
    #1;
    ce = 0;
    delay_load = 0;
  endtask
  task automatic stream6();
    for (int k = 0; k < 20; k++) begin
      step(1, pk(8'(16 * k)), 0, 0);
      chk("s1_valid", 32'(dout_valid), 32'(k >= 6));
      if (k >= 6) chk("s1_dout", dout, pk(8'(16 * (k - 6))));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_delay", 32'(cur_delay), 6);
    rst = 0;
    stream6();
    step(0, 0, 1, 3);
    chk("s2_delay", 32'(cur_delay), 3);
    chk("s2_valid0", 32'(dout_valid), 0);
    for (int j = 0; j < 7; j++) begin
      step(1, pk(8'(16 * j + 5)), 0, 0);
      chk("s2_valid", 32'(dout_valid), 32'(j >= 3));
      if (j >= 3) chk("s2_dout", dout, pk(8'(16 * (j - 3) + 5)));
      for (int g = 0; g < 2; g++) begin
        step(0, 32'hdeadbeef, 0, 0);
        chk("s2_hold_valid", 32'(dout_valid), 32'(j >= 3));
        if (j >= 3) chk("s2_hold_dout", dout, pk(8'(16 * (j - 3) + 5)));
      end
    end
    step(0, 0, 1, 15);
    chk("s3_delay", 32'(cur_delay), 15);
    chk("s3_valid0", 32'(dout_valid), 0);
    for (int i = 0; i < 20; i++) begin
      step(1, pk(8'(8 * i + 2)), 0, 0);
      chk("s3_valid", 32'(dout_valid), 32'(i >= 15));
      if (i >= 15) chk("s3_dout", dout, pk(8'(8 * (i - 15) + 2)));
    end
    step(0, 0, 1, 0);
    chk("s4_delay", 32'(cur_delay), 0);
    chk("s4_valid0", 32'(dout_valid), 0);
    for (int i = 0; i < 5; i++) begin
      step(1, pk(8'(9 * i + 64)), 0, 0);
      chk("s4_valid", 32'(dout_valid), 1);
      chk("s4_dout", dout, pk(8'(9 * i + 64)));
    end
    step(0, 0, 1, 6);
    for (int i = 0; i < 8; i++) begin
      step(1, pk(8'(160 + 4 * i)), 0, 0);
      chk("s5_valid6", 32'(dout_valid), 32'(i >= 6));
      if (i >= 6) chk("s5_dout6", dout, pk(8'(160 + 4 * (i - 6))));
    end
    step(1, pk(8'hE0), 1, 2);
    chk("s5_delay", 32'(cur_delay), 2);
    chk("s5_ld_valid", 32'(dout_valid), 0);
    chk("s5_ld_hold", dout, pk(8'(164)));
    step(1, pk(8'hE8), 0, 0);
    chk("s5_valid_a", 32'(dout_valid), 0);
    step(1, pk(8'hF0), 0, 0);
    chk("s5_valid_b", 32'(dout_valid), 1);
    chk("s5_dout_b", dout, pk(8'hE0));
    step(1, pk(8'hF8), 0, 0);
    chk("s5_dout_c", dout, pk(8'hE8));
    #2;
    rst = 1;
    #1;
    chk("s6_dout", dout, 0);
    chk("s6_valid", 32'(dout_valid), 0);
    chk("s6_delay", 32'(cur_delay), 6);
    @(posedge clk);
    #1;
    rst = 0;
    stream6();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
